// File: rtl/life_keys.sv
// Push-button front end for the Life board: synchronise, debounce and convert
// the six raw pins into single-cycle key pulses, with auto-repeat on all but flip.
module life_keys #(
  parameter int PRESCALE       = 16384,
  parameter int LOG2PRESCALE   = 14,
  parameter int DEBOUNCE       = 4,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8,
  parameter int LOG2REP        = 6,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_nxt,
  input  logic btn_flip,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  output logic key_nxt,
  output logic key_flip,
  output logic key_up,
  output logic key_down,
  output logic key_left,
  output logic key_right,
  output logic tick
);

  localparam int NK = 6;
  localparam int DW = 3;
  // Bit order: nxt, flip, up, down, left, right (LSB first); flip never repeats.
  localparam logic [NK-1:0] REP_EN = 6'b111101;

  localparam logic [LOG2PRESCALE-1:0] PRESC_MAX  = LOG2PRESCALE'(PRESCALE - 1);
  localparam logic [DW-1:0]           DCNT_MAX   = DW'(DEBOUNCE - 1);
  localparam logic [LOG2REP-1:0]      REP_LAST   = LOG2REP'(REPEAT_DELAY - 1);
  localparam logic [LOG2REP-1:0]      REP_RELOAD = LOG2REP'(REPEAT_DELAY - REPEAT_RATE);

  logic [NK-1:0]           btn_raw;
  logic [NK-1:0]           btn_act;
  logic [NK-1:0]           sync1_q, sync1_d;
  logic [NK-1:0]           sync2_q, sync2_d;
  logic [LOG2PRESCALE-1:0] presc_q, presc_d;
  logic                    tick_w;
  logic [NK-1:0]           deb_q, deb_d;
  logic [DW-1:0]           dcnt_q [NK];
  logic [DW-1:0]           dcnt_d [NK];
  logic [LOG2REP-1:0]      rcnt_q [NK];
  logic [LOG2REP-1:0]      rcnt_d [NK];
  logic [NK-1:0]           press;
  logic [NK-1:0]           hit;
  logic [NK-1:0]           pend_q, pend_d;
  logic [NK-1:0]           key_q, key_d;

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up, btn_flip, btn_nxt};
  assign btn_act = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
  assign tick_w  = (presc_q == PRESC_MAX);

  always_comb begin
    sync1_d = btn_act;
    sync2_d = sync1_q;
    presc_d = tick_w ? '0 : presc_q + 1'b1;
    key_d   = pend_q;
  end

  // A sample must disagree with deb on DEBOUNCE consecutive ticks to flip it.
  always_comb begin
    deb_d = deb_q;
    for (int k = 0; k < NK; k++) begin
      dcnt_d[k] = dcnt_q[k];
      if (tick_w) begin
        if (sync2_q[k] != deb_q[k]) begin
          if (dcnt_q[k] == DCNT_MAX) begin
            deb_d[k]  = ~deb_q[k];
            dcnt_d[k] = '0;
          end else begin
            dcnt_d[k] = dcnt_q[k] + 1'b1;
          end
        end else begin
          dcnt_d[k] = '0;
        end
      end
    end
  end

  assign press = deb_d & ~deb_q;

  // The >= compare keeps an out-of-range count from wrapping; a repeat that
  // lands on the tick where the release is accepted is dropped.
  always_comb begin
    hit = '0;
    for (int k = 0; k < NK; k++) begin
      rcnt_d[k] = rcnt_q[k];
      if (!REP_EN[k] || !deb_q[k] || press[k]) begin
        rcnt_d[k] = '0;
      end else if (tick_w) begin
        if (rcnt_q[k] >= REP_LAST) begin
          rcnt_d[k] = REP_RELOAD;
          hit[k]    = deb_d[k];
        end else begin
          rcnt_d[k] = rcnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign pend_d = press | hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
      deb_q   <= '0;
      pend_q  <= '0;
      key_q   <= '0;
      for (int k = 0; k < NK; k++) begin
        dcnt_q[k] <= '0;
        rcnt_q[k] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      presc_q <= presc_d;
      deb_q   <= deb_d;
      pend_q  <= pend_d;
      key_q   <= key_d;
      for (int k = 0; k < NK; k++) begin
        dcnt_q[k] <= dcnt_d[k];
        rcnt_q[k] <= rcnt_d[k];
      end
    end
  end

  assign key_nxt   = key_q[0];
  assign key_flip  = key_q[1];
  assign key_up    = key_q[2];
  assign key_down  = key_q[3];
  assign key_left  = key_q[4];
  assign key_right = key_q[5];
  assign tick      = tick_w;

endmodule

// File: tb/tb_life_keys.sv
// Directed bench for life_keys with a small prescaler: reset, clean press,
// bounce, auto-repeat, simultaneous keys and reset while a key is held.
module tb_life_keys;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_nxt = 1'b1, btn_flip = 1'b1, btn_up = 1'b1;
  logic btn_down = 1'b1, btn_left = 1'b1, btn_right = 1'b1;
  logic key_nxt, key_flip, key_up, key_down, key_left, key_right, tick;
  logic [5:0] keys;

  int total = 0;
  int bad = 0;
  int pulse_n;
  int pulse_at [16];

  life_keys #(
    .PRESCALE(4), .LOG2PRESCALE(2), .DEBOUNCE(2),
    .REPEAT_DELAY(4), .REPEAT_RATE(2), .LOG2REP(3), .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_nxt(btn_nxt), .btn_flip(btn_flip), .btn_up(btn_up),
    .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .key_nxt(key_nxt), .key_flip(key_flip), .key_up(key_up),
    .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .tick(tick)
  );

  always #5 clk = ~clk;

  assign keys = {key_right, key_left, key_down, key_up, key_flip, key_nxt};

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Index order matches the keys vector: nxt, flip, up, down, left, right.
  task automatic apply_stimulus(input int idx, input logic level);
    case (idx)
      0: btn_nxt   = level;
      1: btn_flip  = level;
      2: btn_up    = level;
      3: btn_down  = level;
      4: btn_left  = level;
      default: btn_right = level;
    endcase
  endtask

  // Counts negedges after the call; returns early once stop_after pulses seen.
  task automatic watch(input int idx, input int ncyc, input int stop_after);
    pulse_n = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (keys[idx] === 1'b1) begin
        if (pulse_n < 16) pulse_at[pulse_n] = c;
        pulse_n++;
        if (pulse_n == stop_after) break;
      end
    end
  endtask

  initial begin
    int up_n, down_n, up_at, down_at;

    $display("[TB] reset");
    repeat (5) begin
      @(negedge clk);
      check_output("reset_outputs", {tick, keys}, 0);
    end
    reset = 1'b1;
    // Count is k at the k-th negedge after release; tick while it equals 3.
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check_output($sformatf("tick_c%0d", c), tick, (c % 4 == 3) ? 1 : 0);
      check_output($sformatf("keys_idle_c%0d", c), keys, 0);
    end

    $display("[TB] clean press on flip");
    apply_stimulus(1, 1'b0);
    watch(1, 200, 0);
    check_output("flip_pulse_count", pulse_n, 1);
    check_output("flip_latency_in_8_11",
                 (pulse_n > 0 && pulse_at[0] >= 8 && pulse_at[0] <= 11) ? 1 : 0, 1);
    apply_stimulus(1, 1'b1);
    watch(1, 30, 0);
    check_output("flip_release_silent", pulse_n, 0);

    $display("[TB] bounce on up");
    apply_stimulus(2, 1'b0);
    repeat (3) @(negedge clk);
    apply_stimulus(2, 1'b1);
    watch(2, 30, 0);
    check_output("bounce_rejected", pulse_n, 0);

    $display("[TB] auto-repeat on left");
    apply_stimulus(4, 1'b0);
    watch(4, 80, 6);
    check_output("left_pulse_count", pulse_n, 6);
    check_output("left_first_in_8_11",
                 (pulse_at[0] >= 8 && pulse_at[0] <= 11) ? 1 : 0, 1);
    check_output("left_first_repeat_gap", pulse_at[1] - pulse_at[0], 16);
    check_output("left_repeat_gap_2", pulse_at[2] - pulse_at[1], 8);
    check_output("left_repeat_gap_3", pulse_at[3] - pulse_at[2], 8);
    check_output("left_repeat_gap_5", pulse_at[5] - pulse_at[4], 8);
    // Released right after a repeat: the next repeat would fall on the release tick.
    apply_stimulus(4, 1'b1);
    watch(4, 30, 0);
    check_output("left_release_silent", pulse_n, 0);
    apply_stimulus(4, 1'b0);
    watch(4, 12, 0);
    check_output("left_repress_count", pulse_n, 1);
    check_output("left_repress_in_8_11",
                 (pulse_n > 0 && pulse_at[0] >= 8 && pulse_at[0] <= 11) ? 1 : 0, 1);
    apply_stimulus(4, 1'b1);
    watch(4, 30, 0);
    check_output("left_repress_release_silent", pulse_n, 0);

    $display("[TB] up and down together");
    apply_stimulus(2, 1'b0);
    apply_stimulus(3, 1'b0);
    up_n = 0; down_n = 0; up_at = -1; down_at = -2;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (key_up === 1'b1) begin up_n++; up_at = c; end
      if (key_down === 1'b1) begin down_n++; down_at = c; end
    end
    check_output("simul_up_count", up_n, 1);
    check_output("simul_down_count", down_n, 1);
    check_output("simul_same_cycle", up_at - down_at, 0);
    apply_stimulus(2, 1'b1);
    apply_stimulus(3, 1'b1);
    up_n = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (key_up === 1'b1 || key_down === 1'b1) up_n++;
    end
    check_output("simul_release_silent", up_n, 0);

    $display("[TB] reset while nxt is held");
    apply_stimulus(0, 1'b0);
    watch(0, 40, 2);
    check_output("nxt_prereset_pulses", pulse_n, 2);
    check_output("nxt_prereset_gap", pulse_at[1] - pulse_at[0], 16);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_output("midhold_reset_outputs", {tick, keys}, 0);
    end
    reset = 1'b1;
    watch(0, 30, 0);
    check_output("nxt_after_reset_count", pulse_n, 2);
    check_output("nxt_after_reset_first", pulse_at[0], 9);
    check_output("nxt_after_reset_repeat", pulse_at[1], 25);
    apply_stimulus(0, 1'b1);
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
